// File: rtl/layer_argmax.sv
// layer_argmax: serial argmax over a latched vector of NUM_IN signed 32-bit
// scores. One element is compared per clock, so the datapath is a single
// 32-bit comparator instead of a comparator tree. The result (index, value)
// is held on a valid/ready output until it is taken.
module layer_argmax #(
    parameter int NUM_IN = 10,
    parameter int IDX_W  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [NUM_IN*32-1:0]   in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [IDX_W-1:0]       out_index_o,
    output logic [31:0]            out_value_o,
    output logic                   busy_o
);

    // Counter only has to address elements 0..NUM_IN-1; it wraps to 0 after
    // the last element so it never points outside the latched vector.
    localparam int              CNT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_IN - 1);

    // Parameter sanity: reject configurations that cannot represent the index.
    if (NUM_IN < 1) begin : g_bad_num_in
        $error("layer_argmax: NUM_IN must be >= 1");
    end
    if ((2 ** IDX_W) < NUM_IN) begin : g_bad_idx_w
        $error("layer_argmax: IDX_W too narrow for NUM_IN");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                   state_q;
    logic [NUM_IN*32-1:0]     vec_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [31:0]       max_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     out_valid_q;
    logic                     busy_q;

    logic signed [31:0]       elem;
    logic                     elem_gt;

    // Element under inspection and the strict-greater test (ties keep the lower index).
    always_comb begin
        elem    = vec_q[32*cnt_q +: 32];
        elem_gt = (elem > max_q);
    end

    // in_ready is the only combinational output: it must drop with reset.
    assign in_ready_o  = (state_q == IDLE) && !rst_i;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign out_index_o = idx_q;
    assign out_value_o = max_q;

    // Control FSM plus datapath registers; all outputs registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        vec_q  <= in_data_i;
                        max_q  <= in_data_i[31:0];
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        if (NUM_IN == 1) begin
                            cnt_q       <= '0;
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (elem_gt) begin
                        max_q <= elem;
                        idx_q <= IDX_W'(cnt_q);
                    end
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/layer_argmax.md
# layer_argmax

Classification stage that sits directly downstream of a neuron layer. It accepts the layer's flattened vector of NUM_IN signed 32-bit scores through a valid/ready handshake. It scans the scores serially, one per clock, and returns the index and value of the largest score on a second valid/ready handshake. It turns the output layer's activations into a single class decision without a wide combinational comparator tree.

## Interface
- NUM_IN, default 10: number of 32-bit scores in the input vector; must be ≥ 1.
- IDX_W, default 4: width of the index output; must satisfy 2^IDX_W ≥ NUM_IN. A violation of either parameter rule is an elaboration error.

Ports:
- clk  input  1  the block's single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a score vector.
- in_ready  output  1  block can accept a vector; equals (state == IDLE) and not rst.
- in_data  input  NUM_IN*32  score vector; element i occupies bits [i*32+31 : i*32]; signed two's complement.
- out_valid  output  1  result available; high exactly while in HOLD.
- out_ready  input  1  downstream accepts the result.
- out_index  output  IDX_W  index of the maximum score.
- out_value  output  32  maximum score, signed.
- busy  output  1  high in SCAN or HOLD.

## Operation
- State register: IDLE, SCAN, HOLD. Reset forces IDLE immediately, regardless of clock.
- Reset values:
  - out_valid = 0, busy = 0, out_index = 0, out_value = 0.
  - Element counter = 0; latched vector = 0.
  - in_ready = 0 while rst is high and 1 after release.
- IDLE:
  - An input transfer occurs on an edge where in_valid && in_ready.
  - On that edge: latch the full in_data, set max = element 0, idx = 0, cnt = 1.
  - Go to SCAN if NUM_IN > 1; go to HOLD if NUM_IN == 1.
- SCAN:
  - On each edge, compare element cnt with max as signed 32-bit values.
  - Update max and idx only if element cnt is strictly greater, so ties keep the lower index.
  - Increment cnt on each edge.
  - On the edge that processes element NUM_IN−1, go to HOLD.
  - in_valid is ignored, and upstream data may change freely after the input transfer.
- HOLD:
  - out_valid = 1. out_index and out_value are driven from the idx and max registers and stay stable until the output transfer.
  - On an edge where out_ready is high, go to IDLE. This is the output transfer.
  - in_ready is 0 in HOLD, so no input is accepted in the same cycle as the output transfer.
- out_index and out_value keep their last values in IDLE. They are meaningful only while out_valid is high.
- Comparison is full 32-bit signed. 0x80000000 is the minimum and 0x7FFFFFFF is the maximum. There is no saturation or rounding, and the stored value is the input word unchanged.
- Reset during SCAN or HOLD discards the vector and any pending result. No partial result is ever presented.

## Timing
- Input transfer on edge k means out_valid is high starting with edge k+NUM_IN−1. For NUM_IN = 1, out_valid is high starting at edge k itself, so it is visible in the cycle after acceptance.
- Output transfer on edge m means out_valid is low and in_ready is high after edge m. The next input transfer can occur at edge m+1.
- Throughput is one vector per NUM_IN+1 cycles when out_ready is held high and in_valid is continuously asserted.
- Outputs are registered except in_ready, which is decoded from state and rst.
- out_valid never depends combinationally on out_ready.

## Test plan
- Tie case:
  - Stimulus: NUM_IN = 10, vector [3, −1, 7, 7, 2, 0, −5, 1, 6, 4] accepted at edge k, out_ready = 1.
  - Required: out_valid first seen high after edge k+9, with out_index = 2 and out_value = 7. out_valid is low after edge k+10 and in_ready is high.
- Minimum values: all ten elements = 0x80000000 -> out_index = 0, out_value = 0x80000000.
- Maximum at last element:
  - Stimulus: element 9 = 0x7FFFFFFF, all other elements = 0xFFFFFFFF.
  - Required: out_index = 9, out_value = 0x7FFFFFFF.
- Backpressure:
  - Stimulus: out_ready held low for 5 cycles in HOLD while in_valid = 1 with a new vector.
  - Required: out_valid, out_index and out_value stay stable, and in_ready stays 0. Raising out_ready completes the output transfer, and the new vector is accepted on the next edge.
- Reset mid-scan:
  - Stimulus: assert rst asynchronously 4 cycles into SCAN.
  - Required: out_valid, busy and in_ready go to 0 immediately, and out_index and out_value go to 0. After release, the vector [5, 9, 1, …] yields out_index = 1 and out_value = 9 with normal latency.
- Single-element configuration:
  - Stimulus: NUM_IN = 1, IDX_W = 1, vector [−42] accepted at edge k.
  - Required: out_valid high after edge k, with out_index = 0 and out_value = 0xFFFFFFD6.
